// File: rtl/vad_energy.sv
// Frame-energy voice activity detector: sums |x| over FRAME_LEN samples, compares to a threshold,
// and holds vad_o through HANGOVER_FRAMES quiet frames. Define VAD_ONSET_EN to require ONSET_FRAMES active frames to assert.
module vad_energy #(
  parameter int DATA_W          = 16,
  parameter int FRAME_LEN       = 256,
  parameter int HANGOVER_FRAMES = 4,
  parameter int ONSET_FRAMES    = 2,
  localparam int ACC_W          = DATA_W + $clog2(FRAME_LEN)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic signed [DATA_W-1:0] data_i,
  input  logic                     valid_i,
  input  logic        [ACC_W-1:0]  threshold_i,
  output logic        [ACC_W-1:0]  energy_o,
  output logic                     energy_valid_o,
  output logic                     vad_o
);

  localparam int CNT_W  = $clog2(FRAME_LEN);
  localparam int HANG_W = (HANGOVER_FRAMES > 0) ? $clog2(HANGOVER_FRAMES + 1) : 1;

  if (FRAME_LEN < 2 || (FRAME_LEN & (FRAME_LEN - 1)) != 0) begin : g_bad_frame_len
    $error("vad_energy: FRAME_LEN must be a power of 2 and >= 2");
  end
  if (HANGOVER_FRAMES < 0) begin : g_bad_hangover
    $error("vad_energy: HANGOVER_FRAMES must be >= 0");
  end
  if (ONSET_FRAMES < 1) begin : g_bad_onset
    $error("vad_energy: ONSET_FRAMES must be >= 1");
  end

  typedef enum logic [1:0] {
    S_SILENT = 2'd0,
    S_SPEECH = 2'd1,
    S_HANG   = 2'd2
  } state_t;

  // Two's-complement magnitude; the most negative value yields 2^(DATA_W-1) as unsigned.
  function automatic logic [DATA_W-1:0] abs_mag(input logic signed [DATA_W-1:0] x);
    logic [DATA_W-1:0] u;
    u = x;
    return x[DATA_W-1] ? (~u + 1'b1) : u;
  endfunction

  logic        [CNT_W-1:0]  r_cnt;
  logic        [ACC_W-1:0]  r_acc;
  logic        [ACC_W-1:0]  r_energy_p1;
  logic                     r_energy_vld_p1;
  logic                     r_vad_p1;
  logic        [HANG_W-1:0] r_hang;
  state_t                   r_state;

  logic        [DATA_W-1:0] w_mag_p0;
  logic        [ACC_W-1:0]  w_frame_energy_p0;
  logic                     w_last_p0;
  logic                     w_active_p0;

`ifdef VAD_ONSET_EN
  localparam int ONSET_W = (ONSET_FRAMES > 1) ? $clog2(ONSET_FRAMES + 1) : 1;
  logic [ONSET_W-1:0] r_onset;
`endif

  // Stage p0: magnitude, running sum and the decision for a completing frame
  assign w_mag_p0          = abs_mag(data_i);
  assign w_frame_energy_p0 = r_acc + ACC_W'(w_mag_p0);
  assign w_last_p0         = valid_i && (r_cnt == CNT_W'(FRAME_LEN - 1));
  assign w_active_p0       = w_frame_energy_p0 > threshold_i;

  // Stage p1: registered energy, pulse and hangover state machine
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt           <= '0;
      r_acc           <= '0;
      r_energy_p1     <= '0;
      r_energy_vld_p1 <= 1'b0;
      r_vad_p1        <= 1'b0;
      r_hang          <= '0;
      r_state         <= S_SILENT;
`ifdef VAD_ONSET_EN
      r_onset         <= '0;
`endif
    end else begin
      r_energy_vld_p1 <= 1'b0;
      if (!en_i) begin
        r_cnt    <= '0;
        r_acc    <= '0;
        r_hang   <= '0;
        r_state  <= S_SILENT;
        r_vad_p1 <= 1'b0;
`ifdef VAD_ONSET_EN
        r_onset  <= '0;
`endif
      end else if (valid_i) begin
        r_cnt <= r_cnt + 1'b1;
        if (!w_last_p0) begin
          r_acc <= w_frame_energy_p0;
        end else begin
          r_acc           <= '0;
          r_energy_p1     <= w_frame_energy_p0;
          r_energy_vld_p1 <= 1'b1;
          case (r_state)
            S_SILENT: begin
`ifdef VAD_ONSET_EN
              if (w_active_p0 && r_onset >= ONSET_W'(ONSET_FRAMES - 1)) begin
                r_state  <= S_SPEECH;
                r_vad_p1 <= 1'b1;
                r_hang   <= HANG_W'(HANGOVER_FRAMES);
                r_onset  <= '0;
              end else begin
                r_vad_p1 <= 1'b0;
                r_onset  <= w_active_p0 ? r_onset + 1'b1 : '0;
              end
`else
              if (w_active_p0) begin
                r_state  <= S_SPEECH;
                r_vad_p1 <= 1'b1;
                r_hang   <= HANG_W'(HANGOVER_FRAMES);
              end else begin
                r_vad_p1 <= 1'b0;
              end
`endif
            end
            S_SPEECH: begin
              if (w_active_p0) begin
                r_hang <= HANG_W'(HANGOVER_FRAMES);
              end else if (HANGOVER_FRAMES > 0) begin
                r_state <= S_HANG;
              end else begin
                r_state  <= S_SILENT;
                r_vad_p1 <= 1'b0;
              end
            end
            S_HANG: begin
              if (w_active_p0) begin
                r_state <= S_SPEECH;
                r_hang  <= HANG_W'(HANGOVER_FRAMES);
              end else if (r_hang == HANG_W'(1)) begin
                r_state  <= S_SILENT;
                r_vad_p1 <= 1'b0;
                r_hang   <= '0;
              end else begin
                r_hang <= r_hang - 1'b1;
              end
            end
            default: begin
              r_state  <= S_SILENT;
              r_vad_p1 <= 1'b0;
              r_hang   <= '0;
            end
          endcase
        end
      end
    end
  end

  assign energy_o       = r_energy_p1;
  assign energy_valid_o = r_energy_vld_p1;
  assign vad_o          = r_vad_p1;

endmodule

// File: tb/tb_vad_energy.sv
// Self-checking bench for vad_energy (FRAME_LEN=4, HANGOVER_FRAMES=2, threshold 1000) against a
// frame-level reference model of energy and voice activity.
module tb_vad_energy;

  localparam int DATA_W = 16;
  localparam int ACC_W  = 18;
  localparam int HANG   = 2;
`ifdef VAD_ONSET_EN
  localparam int ONSET_REQ = 2;
`else
  localparam int ONSET_REQ = 1;
`endif

  logic                     clk;
  logic                     rst_i;
  logic                     en_i;
  logic signed [DATA_W-1:0] data_i;
  logic                     valid_i;
  logic        [ACC_W-1:0]  threshold_i;
  logic        [ACC_W-1:0]  energy_o;
  logic                     energy_valid_o;
  logic                     vad_o;

  int checks   = 0;
  int failures = 0;

  // Reference model state: current decision and run lengths of active / inactive frames
  bit m_vad;
  int m_act_run;
  int m_inact_run;

  vad_energy #(
    .DATA_W(DATA_W), .FRAME_LEN(4), .HANGOVER_FRAMES(HANG), .ONSET_FRAMES(2)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .data_i(data_i), .valid_i(valid_i),
    .threshold_i(threshold_i), .energy_o(energy_o), .energy_valid_o(energy_valid_o),
    .vad_o(vad_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    m_vad = 1'b0;
    m_act_run = 0;
    m_inact_run = 0;
  endtask

  task automatic model_frame(input int e);
    if (e > 1000) begin
      m_act_run++;
      m_inact_run = 0;
      if (m_vad || m_act_run >= ONSET_REQ) m_vad = 1'b1;
    end else begin
      m_act_run = 0;
      if (m_vad) begin
        m_inact_run++;
        if (m_inact_run > HANG) m_vad = 1'b0;
      end
    end
  endtask

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1; en_i = 1'b1; valid_i = 1'b0; data_i = '0;
    @(negedge clk);
    rst_i = 1'b0;
    model_clear();
  endtask

  // Drive one sample after gap idle cycles; returns at the negedge after it was consumed.
  task automatic send(input int x, input int gap);
    repeat (gap) begin
      valid_i = 1'b0;
      @(negedge clk);
    end
    data_i  = DATA_W'(x);
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic run_frame(input int s0, input int s1, input int s2, input int s3,
                           input int maxgap, input string nm,
                           output int e_out, output bit v_out);
    int s[4];
    int e;
    s = '{s0, s1, s2, s3};
    e = 0;
    for (int i = 0; i < 4; i++) begin
      send(s[i], $urandom_range(maxgap, 0));
      e += iabs(s[i]);
      if (i < 3) begin
        checks++;
        if (energy_valid_o !== 1'b0 || vad_o !== m_vad) begin
          failures++;
          $display("FAIL %s mid-frame s%0d: energy_valid_o=%b vad_o=%b expected 0/%b",
                   nm, i, energy_valid_o, vad_o, m_vad);
        end
      end
    end
    model_frame(e);
    checks++;
    if (energy_valid_o !== 1'b1) begin
      failures++;
      $display("FAIL %s energy_valid_o: got %b expected 1", nm, energy_valid_o);
    end
    checks++;
    if (energy_o !== ACC_W'(e)) begin
      failures++;
      $display("FAIL %s energy_o: got %0d expected %0d", nm, energy_o, e);
    end
    checks++;
    if (vad_o !== m_vad) begin
      failures++;
      $display("FAIL %s vad_o: got %b expected %b", nm, vad_o, m_vad);
    end
    e_out = int'(energy_o);
    v_out = vad_o;
  endtask

  task automatic test_reset();
    int e; bit v;
    rst_i = 1'b1; en_i = 1'b1; valid_i = 1'b0; data_i = '0; threshold_i = ACC_W'(1000);
    repeat (2) @(negedge clk);
    checks++;
    if (energy_o !== '0 || energy_valid_o !== 1'b0 || vad_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: energy_o=%0d energy_valid_o=%b vad_o=%b expected 0/0/0",
               energy_o, energy_valid_o, vad_o);
    end
    rst_i = 1'b0;
    model_clear();
    run_frame(300, 300, 300, 300, 0, "pre_reset_frame", e, v);
    send(300, 0);
    send(300, 0);
    #2 rst_i = 1'b1;
    #1;
    checks++;
    if (energy_o !== '0 || vad_o !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: energy_o=%0d vad_o=%b expected 0/0", energy_o, vad_o);
    end
    @(negedge clk);
    rst_i = 1'b0;
    model_clear();
    run_frame(300, 300, 300, 300, 0, "after_midframe_reset", e, v);
  endtask

  task automatic test_basic_and_hangover();
    int e; bit v;
    do_reset();
    run_frame(300, -300, 300, -300, 0, "basic_frame", e, v);
    @(negedge clk);
    checks++;
    if (energy_valid_o !== 1'b0 || energy_o !== ACC_W'(1200)) begin
      failures++;
      $display("FAIL pulse_width: energy_valid_o=%b energy_o=%0d expected 0/1200",
               energy_valid_o, energy_o);
    end
    for (int f = 0; f < 3; f++) run_frame(0, 0, 0, 0, 0, "hang_zero", e, v);
    run_frame(400, 400, 400, 400, 0, "reactivate", e, v);
    run_frame(0, 0, 0, 0, 0, "hang_gap", e, v);
    run_frame(-500, 500, 0, 200, 0, "hang_active", e, v);
    for (int f = 0; f < 3; f++) run_frame(0, 0, 0, 0, 0, "hang_tail", e, v);
  endtask

  task automatic test_threshold_and_extreme();
    int e; bit v;
    do_reset();
    run_frame(250, -250, 250, -250, 0, "threshold_equal", e, v);
    run_frame(-32768, -32768, -32768, -32768, 0, "most_negative", e, v);
    run_frame(251, -250, 250, -250, 0, "threshold_plus1", e, v);
  endtask

  task automatic test_back_to_back();
    int fr[8][4];
    int eg[8], eb[8];
    bit vg[8], vb[8];
    for (int f = 0; f < 8; f++)
      for (int i = 0; i < 4; i++) begin
        fr[f][i] = $urandom_range(600, 0);
        if ($urandom_range(1, 0) == 1) fr[f][i] = -fr[f][i];
      end
    do_reset();
    for (int f = 0; f < 8; f++)
      run_frame(fr[f][0], fr[f][1], fr[f][2], fr[f][3], 3, "rand_gapped", eg[f], vg[f]);
    do_reset();
    for (int f = 0; f < 8; f++)
      run_frame(fr[f][0], fr[f][1], fr[f][2], fr[f][3], 0, "rand_b2b", eb[f], vb[f]);
    for (int f = 0; f < 8; f++) begin
      checks++;
      if (eg[f] !== eb[f] || vg[f] !== vb[f]) begin
        failures++;
        $display("FAIL gap_vs_b2b frame %0d: gapped=%0d/%b back_to_back=%0d/%b",
                 f, eg[f], vg[f], eb[f], vb[f]);
      end
    end
  endtask

  task automatic test_enable();
    int e; bit v;
    do_reset();
    run_frame(300, 300, 300, 300, 0, "en_pre", e, v);
    send(300, 0);
    send(300, 0);
    en_i = 1'b0;
    @(negedge clk);
    model_clear();
    checks++;
    if (vad_o !== 1'b0 || energy_valid_o !== 1'b0 || energy_o !== ACC_W'(1200)) begin
      failures++;
      $display("FAIL en_low: vad_o=%b energy_valid_o=%b energy_o=%0d expected 0/0/1200",
               vad_o, energy_valid_o, energy_o);
    end
    for (int i = 0; i < 5; i++) begin
      send(5000, 0);
      checks++;
      if (vad_o !== 1'b0 || energy_valid_o !== 1'b0) begin
        failures++;
        $display("FAIL en_low_samples %0d: vad_o=%b energy_valid_o=%b expected 0/0",
                 i, vad_o, energy_valid_o);
      end
    end
    en_i = 1'b1;
    run_frame(300, 300, 300, 300, 0, "en_reenable", e, v);
  endtask

`ifdef VAD_ONSET_EN
  task automatic test_onset();
    int e; bit v;
    do_reset();
    run_frame(300, 300, 300, 300, 0, "onset_a1", e, v);
    run_frame(0, 0, 0, 0, 0, "onset_i", e, v);
    run_frame(300, 300, 300, 300, 0, "onset_a2", e, v);
    run_frame(300, 300, 300, 300, 0, "onset_a3", e, v);
  endtask
`endif

  initial begin
    test_reset();
    test_basic_and_hangover();
    test_threshold_and_extreme();
    test_back_to_back();
    test_enable();
`ifdef VAD_ONSET_EN
    test_onset();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vad_energy.md
Name: vad_energy

Overview:
- Frame-energy voice activity detector sitting directly upstream of the pipeline control block; its vad_o drives that block's vad_i.
- Consumes signed PCM samples with a valid strobe.
- Sums absolute sample values over fixed-length frames and compares each frame's energy to a programmable threshold.
- Asserts vad_o with hangover so short pauses do not drop activity.

Parameters:
- DATA_W, 16: signed input sample width.
- FRAME_LEN, 256: samples per frame; must be a power of 2, >= 2.
- HANGOVER_FRAMES, 4: inactive frames tolerated before vad_o deasserts; >= 0.
- ONSET_FRAMES, 2: consecutive active frames needed to assert; used only with VAD_ONSET_EN; >= 1.
- ACC_W (derived localparam), DATA_W + $clog2(FRAME_LEN): accumulator/energy width.

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  reset, asynchronous, active-high.
- en_i  input  1  detector enable; low clears frame state and forces vad_o low.
- data_i  input  DATA_W  signed PCM sample.
- valid_i  input  1  data_i valid this cycle; no backpressure, every valid sample is consumed.
- threshold_i  input  ACC_W  unsigned energy threshold; sampled at frame completion.
- energy_o  output  ACC_W  energy of last completed frame.
- energy_valid_o  output  1  one-cycle pulse when energy_o updates.
- vad_o  output  1  voice activity decision.

Behaviour:
- Interface: one clock, clk_i; reset rst_i is asynchronous and active-high.
- Reset (async assert, sync-released by system): all state zero; energy_o=0, energy_valid_o=0, vad_o=0, FSM=SILENT. Reset mid-frame discards the partial frame.
- Magnitude: |x| as unsigned DATA_W bits; -2^(DATA_W-1) maps to 2^(DATA_W-1), not saturated.
- Accumulator:
  - On valid_i & en_i, acc += |x| and sample counter increments.
  - Counter is $clog2(FRAME_LEN) bits and wraps to 0 after FRAME_LEN-1.
  - ACC_W guarantees no overflow, including a frame of all most-negative samples.
- Frame completion (valid_i on counter==FRAME_LEN-1):
  - Next cycle: energy_o = acc + |x|, energy_valid_o=1 for exactly one cycle.
  - Accumulator restarts at 0 in the same edge; a sample on that next cycle belongs to the new frame.
  - Latency: 1 cycle from last sample to energy_valid_o/vad_o update.
- Active frame: energy > threshold_i (strict). Energy == threshold is inactive.
- FSM (updates only on frame-completion edge; hang counter $clog2(HANGOVER_FRAMES+1) bits, min 1):
  - SILENT: active -> SPEECH, vad_o=1, hang=HANGOVER_FRAMES. Inactive -> stay, vad_o=0.
  - SPEECH: active -> stay, hang reloaded. Inactive -> HANG if HANGOVER_FRAMES>0, else SILENT with vad_o=0.
  - HANG: active -> SPEECH, hang reloaded. Inactive: if hang==1 -> SILENT, vad_o=0; else hang-1, vad_o stays 1.
  - Net effect: after the last active frame, vad_o stays high through exactly HANGOVER_FRAMES inactive frames and drops on the next frame completion after those.
  - Illegal state -> SILENT, vad_o=0.
- en_i low:
  - Counter, acc, hang and onset counters clear; FSM -> SILENT; vad_o=0; energy_o holds; no energy_valid_o.
  - Samples are ignored while low.
  - Re-enable starts a fresh frame.
- vad_o is a registered output, glitch-free, changes only on frame-completion edges or en_i/reset.

Optional Feature:
- Macro VAD_ONSET_EN.
- Defined:
  - Onset counter counts consecutive active frames while SILENT; any inactive frame clears it.
  - SILENT -> SPEECH only when the count reaches ONSET_FRAMES. With ONSET_FRAMES=2, vad_o rises on the second consecutive active frame.
  - HANG -> SPEECH still needs only one active frame.
- Undefined: onset logic absent; a single active frame asserts vad_o.

Test Plan (bench params DATA_W=16, FRAME_LEN=4, HANGOVER_FRAMES=2, threshold_i=1000, en_i=1, macro undefined unless noted):
- Reset -> energy_o=0, energy_valid_o=0, vad_o=0; assert rst_i mid-frame after 2 samples, release, send 4 samples of 300 -> energy_o=1200 (partial frame discarded).
- Samples 300,-300,300,-300 back-to-back -> one cycle after 4th valid: energy_o=1200, energy_valid_o single-cycle pulse, vad_o=1.
- Then three frames of zeros -> vad_o stays 1 at frames 1 and 2, falls at 3rd energy_valid_o; active frame during HANG -> vad_o stays 1 continuously.
- Samples 250,-250,250,-250 (energy exactly 1000) -> energy_o=1000, vad_o=0; four samples of -32768 -> energy_o=131072 (ACC_W=18), no wrap, vad_o=1.
- valid_i with random 0-3 idle gaps gives identical energy/vad to back-to-back; en_i low after 2 samples then high, 4 samples of 300 -> energy_o=1200; vad_o=0 while en_i low.
- VAD_ONSET_EN, ONSET_FRAMES=2: active, inactive, active, active frames -> vad_o rises only at 4th energy_valid_o.
